// File: rtl/load_store_queue.sv
// In-order load/store reservation queue feeding the memory functional unit.
// Holds LW/SW ops until their operands resolve off the CDB, then issues the oldest one.
module load_store_queue #(
  parameter int         DEPTH    = 4,
  parameter logic [3:0] TAG_BASE = 4'd8,
  parameter int         ROB_W    = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             dispatch_valid_i,
  input  logic [3:0]       dispatch_op_i,
  input  logic [31:0]      dispatch_vj_i,
  input  logic [3:0]       dispatch_qj_i,
  input  logic [31:0]      dispatch_vk_i,
  input  logic [3:0]       dispatch_qk_i,
  input  logic [31:0]      dispatch_imm_i,
  input  logic [ROB_W-1:0] dispatch_dest_i,
  output logic             full_o,
  output logic [3:0]       dispatch_tag_o,
  input  logic             cdb_valid_i,
  input  logic [3:0]       cdb_tag_i,
  input  logic [31:0]      cdb_data_i,
  output logic             execute_valid_o,
  output logic [3:0]       execute_op_o,
  output logic [31:0]      vj_o,
  output logic [31:0]      vk_o,
  output logic [31:0]      address_o,
  output logic [ROB_W-1:0] dest_o,
  output logic [3:0]       rs_tag_o,
  input  logic             fu_busy_i
);

  localparam int         PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int         CNT_W = PTR_W + 1;
  localparam logic [3:0] OP_LW = 4'b0111;
  localparam logic [3:0] OP_SW = 4'b1000;

  typedef struct packed {
    logic             valid;
    logic [3:0]       op;
    logic [31:0]      vj;
    logic [3:0]       qj;
    logic [31:0]      vk;
    logic [3:0]       qk;
    logic [31:0]      imm;
    logic [ROB_W-1:0] dest;
  } entry_t;

  entry_t           q [DEPTH];
  entry_t           head_e;
  entry_t           new_e;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic             legal_op;
  logic             dispatch_ok;
  logic             issue;

  // A nonzero tag on the bus resolves any operand waiting on that producer.
  function automatic logic cdb_match(input logic [3:0] tag);
    return cdb_valid_i && (cdb_tag_i != 4'd0) && (tag == cdb_tag_i);
  endfunction

  assign head_e      = q[head];
  assign full_o      = (count == CNT_W'(DEPTH));
  assign legal_op    = (dispatch_op_i == OP_LW) || (dispatch_op_i == OP_SW);
  assign dispatch_ok = dispatch_valid_i && !full_o && !flush_i && legal_op;

  assign dispatch_tag_o  = dispatch_ok ? (TAG_BASE + 4'(tail)) : 4'd0;
  assign execute_valid_o = head_e.valid && (head_e.qj == 4'd0) && (head_e.qk == 4'd0) && !fu_busy_i;
  assign issue           = execute_valid_o;
  assign execute_op_o    = head_e.op;
  assign vj_o            = head_e.vj;
  assign vk_o            = head_e.vk;
  assign address_o       = head_e.imm;
  assign dest_o          = head_e.dest;
  assign rs_tag_o        = TAG_BASE + 4'(head);

  always_comb begin
    new_e       = '0;
    new_e.valid = 1'b1;
    new_e.op    = dispatch_op_i;
    new_e.vj    = dispatch_vj_i;
    new_e.qj    = dispatch_qj_i;
    new_e.vk    = dispatch_vk_i;
    new_e.qk    = (dispatch_op_i == OP_LW) ? 4'd0 : dispatch_qk_i;
    new_e.imm   = dispatch_imm_i;
    new_e.dest  = dispatch_dest_i;
    // Catch a producer that broadcasts in the very cycle its consumer dispatches.
    if (cdb_match(new_e.qj)) begin
      new_e.vj = cdb_data_i;
      new_e.qj = 4'd0;
    end
    if (cdb_match(new_e.qk)) begin
      new_e.vk = cdb_data_i;
      new_e.qk = 4'd0;
    end
  end

  // NOTE: all state, including the entry array, updates with non-blocking assignments so every
  // reader in this edge sees pre-edge values; the array is reset too because the packet outputs
  // are defined as zero out of reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < DEPTH; i++) q[i].valid <= 1'b0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q[i].valid) begin
          if (cdb_match(q[i].qj)) begin
            q[i].vj <= cdb_data_i;
            q[i].qj <= 4'd0;
          end
          if (cdb_match(q[i].qk)) begin
            q[i].vk <= cdb_data_i;
            q[i].qk <= 4'd0;
          end
        end
      end
      // The tail slot is never valid while dispatch is allowed, so it cannot collide with snoop or issue.
      if (issue) begin
        q[head].valid <= 1'b0;
        head          <= head + PTR_W'(1);
      end
      if (dispatch_ok) begin
        q[tail] <= new_e;
        tail    <= tail + PTR_W'(1);
      end
      if (dispatch_ok && !issue)      count <= count + CNT_W'(1);
      else if (!dispatch_ok && issue) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue: one task per scenario, inline comparisons, one summary line.
module tb_load_store_queue;

  localparam logic [3:0] LW = 4'b0111;
  localparam logic [3:0] SW = 4'b1000;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        flush_i;
  logic        dispatch_valid_i;
  logic [3:0]  dispatch_op_i;
  logic [31:0] dispatch_vj_i;
  logic [3:0]  dispatch_qj_i;
  logic [31:0] dispatch_vk_i;
  logic [3:0]  dispatch_qk_i;
  logic [31:0] dispatch_imm_i;
  logic [3:0]  dispatch_dest_i;
  logic        full_o;
  logic [3:0]  dispatch_tag_o;
  logic        cdb_valid_i;
  logic [3:0]  cdb_tag_i;
  logic [31:0] cdb_data_i;
  logic        execute_valid_o;
  logic [3:0]  execute_op_o;
  logic [31:0] vj_o;
  logic [31:0] vk_o;
  logic [31:0] address_o;
  logic [3:0]  dest_o;
  logic [3:0]  rs_tag_o;
  logic        fu_busy_i;

  int n_cmp = 0;
  int n_err = 0;

  load_store_queue #(.DEPTH(4), .TAG_BASE(4'd8), .ROB_W(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_op_i(dispatch_op_i),
    .dispatch_vj_i(dispatch_vj_i), .dispatch_qj_i(dispatch_qj_i),
    .dispatch_vk_i(dispatch_vk_i), .dispatch_qk_i(dispatch_qk_i),
    .dispatch_imm_i(dispatch_imm_i), .dispatch_dest_i(dispatch_dest_i),
    .full_o(full_o), .dispatch_tag_o(dispatch_tag_o),
    .cdb_valid_i(cdb_valid_i), .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i),
    .execute_valid_o(execute_valid_o), .execute_op_o(execute_op_o),
    .vj_o(vj_o), .vk_o(vk_o), .address_o(address_o), .dest_o(dest_o),
    .rs_tag_o(rs_tag_o), .fu_busy_i(fu_busy_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i          = 1'b0;
    dispatch_valid_i = 1'b0;
    dispatch_op_i    = 4'd0;
    dispatch_vj_i    = '0;
    dispatch_qj_i    = 4'd0;
    dispatch_vk_i    = '0;
    dispatch_qk_i    = 4'd0;
    dispatch_imm_i   = '0;
    dispatch_dest_i  = 4'd0;
    cdb_valid_i      = 1'b0;
    cdb_tag_i        = 4'd0;
    cdb_data_i       = '0;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] vj, input logic [3:0] qj,
                       input logic [31:0] vk, input logic [3:0] qk, input logic [31:0] imm,
                       input logic [3:0] dest);
    dispatch_valid_i = 1'b1;
    dispatch_op_i    = op;
    dispatch_vj_i    = vj;
    dispatch_qj_i    = qj;
    dispatch_vk_i    = vk;
    dispatch_qk_i    = qk;
    dispatch_imm_i   = imm;
    dispatch_dest_i  = dest;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] data);
    cdb_valid_i = 1'b1;
    cdb_tag_i   = tag;
    cdb_data_i  = data;
  endtask

  task automatic reset_pulse();
    reset_i = 1'b1;
    #1;
    n_cmp++; if (execute_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_exec_valid: got %b want 0", execute_valid_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full_o); end
    n_cmp++; if ({execute_op_o, vj_o, vk_o, address_o, dest_o} !== 104'd0) begin n_err++; $display("FAIL reset_packet: op=%h vj=%h vk=%h addr=%h dest=%h want all 0", execute_op_o, vj_o, vk_o, address_o, dest_o); end
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    fu_busy_i = 1'b0;
    #1;
    reset_pulse();
    drive(4'b0001, 32'h1, 4'd0, 32'h0, 4'd0, 32'h0, 4'd0);
    #1;
    n_cmp++; if (dispatch_tag_o !== 4'd0) begin n_err++; $display("FAIL illegal_op_tag: got %h want 0", dispatch_tag_o); end
    tick();
    idle();
    #1;
    n_cmp++; if (execute_valid_o !== 1'b0) begin n_err++; $display("FAIL illegal_op_dropped: exec_valid got %b want 0", execute_valid_o); end
  endtask

  task automatic test_lw();
    drive(LW, 32'h100, 4'd0, 32'h0, 4'd0, 32'h4, 4'd3);
    #1;
    n_cmp++; if (dispatch_tag_o !== 4'd8) begin n_err++; $display("FAIL lw_dispatch_tag: got %h want 8", dispatch_tag_o); end
    n_cmp++; if (execute_valid_o !== 1'b0) begin n_err++; $display("FAIL lw_empty_exec: got %b want 0", execute_valid_o); end
    tick();
    idle();
    #1;
    n_cmp++; if (execute_valid_o !== 1'b1) begin n_err++; $display("FAIL lw_exec_valid: got %b want 1", execute_valid_o); end
    n_cmp++; if ({execute_op_o, vj_o, address_o, rs_tag_o, dest_o} !== {LW, 32'h100, 32'h4, 4'd8, 4'd3}) begin
      n_err++; $display("FAIL lw_packet: op=%h vj=%h addr=%h tag=%h dest=%h want op=7 vj=100 addr=4 tag=8 dest=3", execute_op_o, vj_o, address_o, rs_tag_o, dest_o);
    end
    tick();
    n_cmp++; if (execute_valid_o !== 1'b0) begin n_err++; $display("FAIL lw_drained: got %b want 0", execute_valid_o); end
  endtask

  task automatic test_sw_cdb();
    drive(SW, 32'h11, 4'd5, 32'h22, 4'd6, 32'h10, 4'd4);
    #1;
    n_cmp++; if (dispatch_tag_o !== 4'd9) begin n_err++; $display("FAIL sw_dispatch_tag: got %h want 9", dispatch_tag_o); end
    tick();
    idle();
    cdb(4'd5, 32'h200);
    #1;
    n_cmp++; if (execute_valid_o !== 1'b0) begin n_err++; $display("FAIL sw_wait_both: got %b want 0", execute_valid_o); end
    tick();
    cdb(4'd6, 32'hDEAD);
    #1;
    n_cmp++; if (execute_valid_o !== 1'b0) begin n_err++; $display("FAIL sw_no_bypass: got %b want 0", execute_valid_o); end
    tick();
    idle();
    #1;
    n_cmp++; if (execute_valid_o !== 1'b1) begin n_err++; $display("FAIL sw_exec_valid: got %b want 1", execute_valid_o); end
    n_cmp++; if ({execute_op_o, vj_o, vk_o, address_o, rs_tag_o} !== {SW, 32'h200, 32'hDEAD, 32'h10, 4'd9}) begin
      n_err++; $display("FAIL sw_packet: op=%h vj=%h vk=%h addr=%h tag=%h want op=8 vj=200 vk=dead addr=10 tag=9", execute_op_o, vj_o, vk_o, address_o, rs_tag_o);
    end
    tick();
    n_cmp++; if (execute_valid_o !== 1'b0) begin n_err++; $display("FAIL sw_drained: got %b want 0", execute_valid_o); end
  endtask

  task automatic test_dispatch_forward();
    drive(LW, 32'h0, 4'd7, 32'h0, 4'd0, 32'h8, 4'd5);
    cdb(4'd7, 32'h40);
    #1;
    n_cmp++; if (dispatch_tag_o !== 4'd10) begin n_err++; $display("FAIL fwd_dispatch_tag: got %h want a", dispatch_tag_o); end
    tick();
    idle();
    #1;
    n_cmp++; if ({execute_valid_o, vj_o, rs_tag_o} !== {1'b1, 32'h40, 4'd10}) begin
      n_err++; $display("FAIL fwd_issue: valid=%b vj=%h tag=%h want valid=1 vj=40 tag=a", execute_valid_o, vj_o, rs_tag_o);
    end
    tick();
  endtask

  task automatic test_full_wrap();
    logic [3:0]  exp_tag  [4] = '{4'd9, 4'd10, 4'd11, 4'd8};
    logic [31:0] exp_addr [4] = '{32'h1, 32'h2, 32'h3, 32'h77};
    reset_pulse();
    fu_busy_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(LW, 32'h10 * i, 4'd0, 32'h0, 4'd0, 32'(i), 4'(i));
      #1;
      n_cmp++; if (dispatch_tag_o !== 4'(8 + i)) begin n_err++; $display("FAIL fill_tag_%0d: got %h want %h", i, dispatch_tag_o, 4'(8 + i)); end
      tick();
    end
    drive(LW, 32'h55, 4'd0, 32'h0, 4'd0, 32'h55, 4'd9);
    #1;
    n_cmp++; if ({full_o, dispatch_tag_o, execute_valid_o} !== {1'b1, 4'd0, 1'b0}) begin
      n_err++; $display("FAIL full_refuse: full=%b tag=%h exec=%b want full=1 tag=0 exec=0", full_o, dispatch_tag_o, execute_valid_o);
    end
    fu_busy_i = 1'b0;
    #1;
    n_cmp++; if ({execute_valid_o, rs_tag_o, dispatch_tag_o} !== {1'b1, 4'd8, 4'd0}) begin
      n_err++; $display("FAIL full_pop_no_bypass: exec=%b rs_tag=%h tag=%h want exec=1 rs_tag=8 tag=0", execute_valid_o, rs_tag_o, dispatch_tag_o);
    end
    tick();
    fu_busy_i = 1'b1;
    idle();
    #1;
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL after_pop_full: got %b want 0", full_o); end
    drive(LW, 32'h70, 4'd0, 32'h0, 4'd0, 32'h77, 4'd7);
    #1;
    n_cmp++; if (dispatch_tag_o !== 4'd8) begin n_err++; $display("FAIL wrap_tag: got %h want 8", dispatch_tag_o); end
    tick();
    idle();
    #1;
    n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL refull: got %b want 1", full_o); end
    fu_busy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++; if ({execute_valid_o, rs_tag_o, address_o} !== {1'b1, exp_tag[i], exp_addr[i]}) begin
        n_err++; $display("FAIL drain_%0d: exec=%b tag=%h addr=%h want exec=1 tag=%h addr=%h", i, execute_valid_o, rs_tag_o, address_o, exp_tag[i], exp_addr[i]);
      end
      tick();
    end
    n_cmp++; if (execute_valid_o !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", execute_valid_o); end
  endtask

  task automatic test_in_order();
    drive(LW, 32'h0, 4'd9, 32'h0, 4'd0, 32'h20, 4'd1);
    #1;
    n_cmp++; if (dispatch_tag_o !== 4'd9) begin n_err++; $display("FAIL order_tag_old: got %h want 9", dispatch_tag_o); end
    tick();
    drive(LW, 32'h300, 4'd0, 32'h0, 4'd0, 32'h30, 4'd2);
    tick();
    idle();
    #1;
    n_cmp++; if (execute_valid_o !== 1'b0) begin n_err++; $display("FAIL order_blocked: got %b want 0", execute_valid_o); end
    tick();
    cdb(4'd9, 32'h900);
    #1;
    n_cmp++; if (execute_valid_o !== 1'b0) begin n_err++; $display("FAIL order_no_bypass: got %b want 0", execute_valid_o); end
    tick();
    idle();
    #1;
    n_cmp++; if ({execute_valid_o, vj_o, address_o, rs_tag_o} !== {1'b1, 32'h900, 32'h20, 4'd9}) begin
      n_err++; $display("FAIL order_head: exec=%b vj=%h addr=%h tag=%h want exec=1 vj=900 addr=20 tag=9", execute_valid_o, vj_o, address_o, rs_tag_o);
    end
    tick();
    n_cmp++; if ({execute_valid_o, vj_o, address_o, rs_tag_o} !== {1'b1, 32'h300, 32'h30, 4'd10}) begin
      n_err++; $display("FAIL order_young: exec=%b vj=%h addr=%h tag=%h want exec=1 vj=300 addr=30 tag=a", execute_valid_o, vj_o, address_o, rs_tag_o);
    end
    tick();
    n_cmp++; if (execute_valid_o !== 1'b0) begin n_err++; $display("FAIL order_empty: got %b want 0", execute_valid_o); end
  endtask

  task automatic test_flush_and_async_reset();
    fu_busy_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(LW, 32'h500 + 32'(i), 4'd0, 32'h0, 4'd0, 32'h0, 4'd0);
      tick();
    end
    idle();
    flush_i   = 1'b1;
    fu_busy_i = 1'b0;
    drive(LW, 32'h1, 4'd0, 32'h0, 4'd0, 32'h0, 4'd0);
    #1;
    n_cmp++; if ({execute_valid_o, vj_o, dispatch_tag_o} !== {1'b1, 32'h500, 4'd0}) begin
      n_err++; $display("FAIL flush_cycle: exec=%b vj=%h tag=%h want exec=1 vj=500 tag=0", execute_valid_o, vj_o, dispatch_tag_o);
    end
    tick();
    idle();
    #1;
    n_cmp++; if ({execute_valid_o, full_o} !== 2'b00) begin n_err++; $display("FAIL flush_empty: exec=%b full=%b want 0 0", execute_valid_o, full_o); end
    fu_busy_i = 1'b1;
    drive(LW, 32'hABC, 4'd0, 32'h0, 4'd0, 32'h44, 4'd6);
    #1;
    n_cmp++; if (dispatch_tag_o !== 4'd8) begin n_err++; $display("FAIL flush_tail_reset: got %h want 8", dispatch_tag_o); end
    tick();
    drive(LW, 32'hDEF, 4'd0, 32'h0, 4'd0, 32'h48, 4'd7);
    fu_busy_i = 1'b0;
    #1;
    n_cmp++; if ({execute_valid_o, vj_o} !== {1'b1, 32'hABC}) begin n_err++; $display("FAIL pre_reset_head: exec=%b vj=%h want 1 abc", execute_valid_o, vj_o); end
    #1;
    reset_i = 1'b1;
    #1;
    n_cmp++; if ({execute_valid_o, full_o, vj_o, address_o, execute_op_o} !== {1'b0, 1'b0, 32'h0, 32'h0, 4'd0}) begin
      n_err++; $display("FAIL async_reset: exec=%b full=%b vj=%h addr=%h op=%h want all 0", execute_valid_o, full_o, vj_o, address_o, execute_op_o);
    end
    idle();
    tick();
    reset_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_cdb();
    test_dispatch_forward();
    test_full_wrap();
    test_in_order();
    test_flush_and_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_queue.md
Name: load_store_queue

Overview:
- In-order reservation buffer for LW/SW, directly upstream of the memory functional unit.
- Accepts memory ops from dispatch and holds each one until its operands are resolved, snooping the CDB to capture them.
- Issues the oldest entry to the memory unit with a single-cycle accept handshake.
- Strict program order between all memory ops; no load bypassing.

Parameters:
DEPTH, 4, number of entries (power of two, 2..8)
TAG_BASE, 4'd8, RS tag of entry 0; entry i carries tag TAG_BASE+i; tag 0 is reserved as "operand ready"
ROB_W, 4, width of ROB entry index

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
flush_i  in  1  synchronous flush (mispredict); invalidates all entries
dispatch_valid_i  in  1  new memory op presented
dispatch_op_i  in  4  4'b0111 LW, 4'b1000 SW; others illegal, dropped
dispatch_vj_i  in  32  base register value
dispatch_qj_i  in  4  producer tag of base (0 = ready)
dispatch_vk_i  in  32  store data value
dispatch_qk_i  in  4  producer tag of store data (0 = ready)
dispatch_imm_i  in  32  address offset
dispatch_dest_i  in  ROB_W  ROB entry
full_o  out  1  count == DEPTH
dispatch_tag_o  out  4  tag assigned to an accepted dispatch (TAG_BASE + tail index)
cdb_valid_i  in  1  CDB broadcast valid
cdb_tag_i  in  4  CDB producer tag
cdb_data_i  in  32  CDB value
execute_valid_o  out  1  head entry ready to issue
execute_op_o / vj_o / vk_o / address_o / dest_o  out  4/32/32/32/ROB_W  head packet fields
rs_tag_o  out  4  head entry tag
fu_busy_i  in  1  memory unit cannot accept this cycle

Behaviour:
- Reset (async): all entries invalid, head = tail = count = 0; full_o = 0, execute_valid_o = 0; packet outputs are 0.
- Storage: circular buffer of DEPTH entries, each holding valid, op, vj, qj, vk, qk, imm, dest. Pointers wrap modulo DEPTH.
- Dispatch:
  - Accepted iff dispatch_valid_i && !full_o && !flush_i && legal op.
  - Entry written at tail; tail++, count++.
  - For LW, qk is forced to 0.
- Dispatch-cycle CDB forwarding: if cdb_valid_i and cdb_tag_i equals a nonzero dispatch_qj_i or dispatch_qk_i, the entry is written with the CDB data and the matching q cleared.
- CDB snoop (every cycle), for every valid entry:
  - qj == cdb_tag_i (nonzero) → vj <= cdb_data_i, qj <= 0.
  - Same rule independently for qk.
- Issue:
  - execute_valid_o = head valid && head.qj == 0 && head.qk == 0 && !fu_busy_i.
  - Combinational; the packet outputs always reflect the head entry.
  - address_o carries imm only; the memory unit adds vj.
  - When execute_valid_o is high the handoff completes that cycle: head invalidated, head++, count--.
- Operand readiness is registered: an operand resolved on the CDB this cycle makes the head issuable the next cycle. No same-cycle CDB-to-issue bypass.
- Simultaneous dispatch and issue: count unchanged.
  - When full, dispatch is still refused even if an issue occurs that cycle; full_o has no bypass.
- Flush:
  - Flush clears all entries and pointers next edge, and overrides dispatch, snoop and issue.
  - execute_valid_o is still combinationally visible in the flush cycle; the memory unit and ROB discard it.
- Tags: dispatch_tag_o = TAG_BASE + tail, valid only when dispatch is accepted.
  - Entries never share a tag because each index is unique while valid.
- Empty: execute_valid_o = 0 and packet outputs hold the stale head-slot contents (don't-care).

Test Plan:
- Reset, then dispatch LW vj=0x100, qj=0, imm=4, dest=3 with fu_busy_i=0 → next cycle execute_valid_o=1, vj_o=0x100, address_o=4, rs_tag_o=8, dest_o=3; the following cycle count=0.
- Dispatch SW qj=5, qk=6 → no issue; CDB tag5=0x200, then tag6=0xDEAD on the next cycle → issue one cycle after the tag6 broadcast with vj_o=0x200, vk_o=0xDEAD.
- Dispatch with qj=7 in the same cycle CDB broadcasts tag7=0x40 → entry stored ready; issues the next cycle with vj_o=0x40.
- Fill 4 entries with fu_busy_i=1 → full_o=1 and a 5th dispatch is refused. Release busy for one cycle → one pop, full_o=0. Fill again to check tail wrap: new tag is 8 again.
- Older head not ready (qj=9) with a younger entry ready → nothing issues (in-order). Broadcast tag9 → head issues, then younger issues next cycle.
- 3 entries valid, assert flush_i → next cycle count=0, execute_valid_o=0. Then assert reset_i asynchronously mid-dispatch → outputs 0 immediately, before the next clock edge.
